// File: rtl/cpu_ahb_rdata_align.sv
// Purpose : AHB read-data lane aligner. It tracks the data phase of every accepted transfer
//           and steers the addressed byte lanes of s_hrdata to the master.
// Latency : m_hrdata and the completion pulses are combinational in the data-phase cycle.
//           The context and the FSM advance on the next cpu_clk edge.
// Backpr. : none of its own. It follows s_hready, and nothing advances while s_hready is low.
//
// Ports
//   cpu_clk, pad_cpu_rst_b      : clock (rising edge), asynchronous active-low reset
//   m_haddr/m_htrans/m_hsize/
//   m_hwrite                    : master address-phase signals
//   s_hready/s_hresp/s_hrdata   : slave response and raw read data (only s_hresp[0] is used)
//   bigend_b                    : static lane order, 1 = little-endian, 0 = big-endian
//   m_hrdata                    : aligned read data (zero when the context is illegal)
//   rd_data_vld                 : pulses on an OKAY read completion with a legal context
//   rd_err                      : pulses on an ERROR completion, read or write
//   rd_misalign                 : pulses on a read completion with an illegal size or address
//   err_cnt                     : saturating count of ERROR completions
//   busy                        : a data phase is pending
module cpu_ahb_rdata_align #(
   parameter int DATA_W     = 32,
   parameter int ALIGN_MODE = 0,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                 cpu_clk,
   input  logic                 pad_cpu_rst_b,
   input  logic [31:0]          m_haddr,
   input  logic [1:0]           m_htrans,
   input  logic [2:0]           m_hsize,
   input  logic                 m_hwrite,
   input  logic                 s_hready,
   input  logic [1:0]           s_hresp,
   input  logic [DATA_W-1:0]    s_hrdata,
   input  logic                 bigend_b,
   output logic [DATA_W-1:0]    m_hrdata,
   output logic                 rd_data_vld,
   output logic                 rd_err,
   output logic                 rd_misalign,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic                 busy
);

   localparam int         NB        = DATA_W / 8;
   localparam int         AW        = $clog2(NB);
   localparam logic [2:0] SIZE_FULL = 3'(AW);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_DATA = 2'd1,
      WR_DATA = 2'd2,
      ERR2    = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           size_q, size_d;
   logic                 write_q, write_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic                 accept;
   logic                 data_cyc;
   logic                 ctx_illegal;
   int                   size_bytes;
   int                   lane_off;
   logic [DATA_W-1:0]    shifted;
   logic [DATA_W-1:0]    rdata_algn;

   // The upper address bits and HRESP[1] play no part in lane selection. The write flag
   // stays in the context so that the data-phase direction is visible when debugging.
   logic unused_ok;
   assign unused_ok = ^{m_haddr[31:AW], s_hresp[1], write_q};

   // Only NONSEQ and SEQ are accepted, and only in a cycle where the bus moves.
   assign accept = s_hready & m_htrans[1];

   // ------------------------------------------------------------------------
   // Data-phase FSM
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (s_hready) begin
         // Completion cycle: a new address phase in the same cycle starts its data phase
         // straight away, so pipelined transfers carry no bubble.
         if (accept) begin
            state_d = m_hwrite ? WR_DATA : RD_DATA;
         end else begin
            state_d = IDLE;
         end
      end else if (((state_q == RD_DATA) || (state_q == WR_DATA)) && s_hresp[0]) begin
         // First cycle of the two-cycle ERROR response.
         state_d = ERR2;
      end
   end

   // ------------------------------------------------------------------------
   // Data-phase context. It is captured only when the bus moves, so m_htrans changing
   // during wait states cannot disturb the transfer in flight.
   // ------------------------------------------------------------------------
   always_comb begin
      size_d  = size_q;
      write_d = write_q;
      addr_d  = addr_q;
      if (accept) begin
         size_d  = m_hsize;
         write_d = m_hwrite;
         addr_d  = m_haddr[AW-1:0];
      end
   end

   // ------------------------------------------------------------------------
   // Error counter. It saturates at all-ones.
   // ------------------------------------------------------------------------
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (rd_err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   // The reset context is full width at offset 0, so m_hrdata passes s_hrdata straight
   // through while in reset without any extra mux.
   always_ff @(posedge cpu_clk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) begin
         state_q   <= IDLE;
         size_q    <= SIZE_FULL;
         write_q   <= 1'b0;
         addr_q    <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         size_q    <= size_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Lane selection
   // ------------------------------------------------------------------------
   always_comb begin
      size_bytes  = 1 << size_q;
      ctx_illegal = (size_q > SIZE_FULL) || ((int'(addr_q) & (size_bytes - 1)) != 0);

      // For big-endian, the lowest-addressed byte sits in the most significant lane, so
      // the window is mirrored within the bus. For an illegal context the offset is forced
      // to 0 so the shift amount never goes negative. The data is zeroed below anyway.
      if (ctx_illegal) begin
         lane_off = 0;
      end else if (bigend_b) begin
         lane_off = int'(addr_q);
      end else begin
         lane_off = NB - size_bytes - int'(addr_q);
      end

      shifted    = s_hrdata >> (8 * lane_off);
      rdata_algn = '0;
      for (int i = 0; i < NB; i++) begin
         if (ALIGN_MODE == 0) begin
            // The addressed lanes stay in place. Every other lane is zeroed.
            if ((i >= lane_off) && (i < (lane_off + size_bytes))) begin
               rdata_algn[8*i +: 8] = s_hrdata[8*i +: 8];
            end
         end else begin
            // The addressed lanes are right-justified and zero-extended.
            if (i < size_bytes) begin
               rdata_algn[8*i +: 8] = shifted[8*i +: 8];
            end
         end
      end

      if (ctx_illegal) begin
         rdata_algn = '0;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs. Every pulse is qualified by a non-IDLE state, so all pulses are quiet in
   // IDLE and while in reset.
   // ------------------------------------------------------------------------
   assign data_cyc    = (state_q == RD_DATA) & s_hready & ~s_hresp[0];
   assign rd_data_vld = data_cyc & ~ctx_illegal;
   assign rd_misalign = data_cyc & ctx_illegal;
   assign rd_err      = (state_q == ERR2) & s_hready;
   assign m_hrdata    = rdata_algn;
   assign err_cnt     = err_cnt_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_cpu_ahb_rdata_align.sv
module tb_cpu_ahb_rdata_align;

   localparam logic [1:0] T_IDLE = 2'b00;
   localparam logic [1:0] T_NSEQ = 2'b10;
   localparam logic [1:0] T_SEQ  = 2'b11;
   localparam int K_VLD = 0;
   localparam int K_ERR = 1;
   localparam int K_MIS = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [31:0] haddr   [3];
   logic [1:0]  htrans  [3];
   logic [2:0]  hsize   [3];
   logic        hwrite  [3];
   logic        hready  [3];
   logic [1:0]  hresp   [3];
   logic [63:0] hrdata  [3];
   logic        bigend  [3];
   logic        vld     [3];
   logic        err     [3];
   logic        mis     [3];
   logic        bsy     [3];
   logic [31:0] out0, out2;
   logic [63:0] out1;
   logic [7:0]  ec0, ec1;
   logic [1:0]  ec2;

   // Instance 0: 32-bit bus, lanes kept in place
   cpu_ahb_rdata_align #(.DATA_W(32), .ALIGN_MODE(0), .ERR_CNT_W(8)) u_dut0 (
      .cpu_clk(clk), .pad_cpu_rst_b(rst_n),
      .m_haddr(haddr[0]), .m_htrans(htrans[0]), .m_hsize(hsize[0]), .m_hwrite(hwrite[0]),
      .s_hready(hready[0]), .s_hresp(hresp[0]), .s_hrdata(hrdata[0][31:0]), .bigend_b(bigend[0]),
      .m_hrdata(out0), .rd_data_vld(vld[0]), .rd_err(err[0]), .rd_misalign(mis[0]),
      .err_cnt(ec0), .busy(bsy[0]));

   // Instance 1: 64-bit bus, lanes right-justified
   cpu_ahb_rdata_align #(.DATA_W(64), .ALIGN_MODE(1), .ERR_CNT_W(8)) u_dut1 (
      .cpu_clk(clk), .pad_cpu_rst_b(rst_n),
      .m_haddr(haddr[1]), .m_htrans(htrans[1]), .m_hsize(hsize[1]), .m_hwrite(hwrite[1]),
      .s_hready(hready[1]), .s_hresp(hresp[1]), .s_hrdata(hrdata[1]), .bigend_b(bigend[1]),
      .m_hrdata(out1), .rd_data_vld(vld[1]), .rd_err(err[1]), .rd_misalign(mis[1]),
      .err_cnt(ec1), .busy(bsy[1]));

   // Instance 2: 32-bit bus, lanes right-justified, 2-bit error counter
   cpu_ahb_rdata_align #(.DATA_W(32), .ALIGN_MODE(1), .ERR_CNT_W(2)) u_dut2 (
      .cpu_clk(clk), .pad_cpu_rst_b(rst_n),
      .m_haddr(haddr[2]), .m_htrans(htrans[2]), .m_hsize(hsize[2]), .m_hwrite(hwrite[2]),
      .s_hready(hready[2]), .s_hresp(hresp[2]), .s_hrdata(hrdata[2][31:0]), .bigend_b(bigend[2]),
      .m_hrdata(out2), .rd_data_vld(vld[2]), .rd_err(err[2]), .rd_misalign(mis[2]),
      .err_cnt(ec2), .busy(bsy[2]));

   typedef struct {
      int          kind;
      logic [63:0] data;
      int          cnt;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk_d(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic chk_b(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, act, req);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic exp_push(input int d, input int kind, input logic [63:0] data, input int cnt);
      exp_t e;
      e.kind = kind;
      e.data = data;
      e.cnt  = cnt;
      case (d)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Monitor: every completion pulse pops one expectation for that instance.
   task automatic mon(input int d, input logic v, input logic e, input logic m,
                      input logic [63:0] data, input int cnt);
      exp_t x;
      int   kind;
      int   qsz;
      if (!(v || e || m)) return;
      kind = v ? K_VLD : (e ? K_ERR : K_MIS);
      chk_i($sformatf("dut%0d_pulse_onehot", d), $countones({v, e, m}), 1);
      case (d)
         0:       qsz = q0.size();
         1:       qsz = q1.size();
         default: qsz = q2.size();
      endcase
      if (qsz == 0) begin
         checks++;
         errors++;
         $display("FAIL dut%0d_unexpected_pulse: got pulse kind %0d, expected none", d, kind);
         return;
      end
      case (d)
         0:       x = q0.pop_front();
         1:       x = q1.pop_front();
         default: x = q2.pop_front();
      endcase
      chk_i($sformatf("dut%0d_kind", d), kind, x.kind);
      if (x.kind == K_ERR) chk_i($sformatf("dut%0d_err_cnt_at_err", d), cnt, x.cnt);
      else                 chk_d($sformatf("dut%0d_rdata", d), data, x.data);
   endtask

   always @(negedge clk) begin
      mon(0, vld[0], err[0], mis[0], {32'd0, out0}, int'(ec0));
      mon(1, vld[1], err[1], mis[1], out1,          int'(ec1));
      mon(2, vld[2], err[2], mis[2], {32'd0, out2}, int'(ec2));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete transfer: address phase, optional wait states, an optional two-cycle
   // ERROR response, then the completing cycle.
   task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [63:0] dat, input int waits, input logic is_err);
      htrans[d] = T_NSEQ; haddr[d] = a; hsize[d] = sz; hwrite[d] = wr;
      hready[d] = 1'b1;   hresp[d] = 2'b00;
      step();
      htrans[d] = T_IDLE;
      for (int w = 0; w < waits; w++) begin
         hready[d] = 1'b0; hresp[d] = 2'b00;
         step();
      end
      if (is_err) begin
         hready[d] = 1'b0; hresp[d] = 2'b01;
         step();
         hready[d] = 1'b1; hresp[d] = 2'b01;
      end else begin
         hready[d] = 1'b1; hresp[d] = 2'b00;
      end
      hrdata[d] = dat;
      step();
      hresp[d] = 2'b00;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         haddr[d] = 32'd0; htrans[d] = T_IDLE; hsize[d] = 3'd0; hwrite[d] = 1'b0;
         hready[d] = 1'b1; hresp[d] = 2'b00; bigend[d] = 1'b1;
      end
      hrdata[0] = 64'h0000_0000_CAFE_F00D;
      hrdata[1] = 64'h0123_4567_89AB_CDEF;
      hrdata[2] = 64'h0000_0000_1357_9BDF;
      #12;
      // Reset state
      for (int d = 0; d < 3; d++) begin
         chk_b($sformatf("rst_busy%0d", d), bsy[d], 1'b0);
         chk_b($sformatf("rst_vld%0d", d),  vld[d], 1'b0);
         chk_b($sformatf("rst_err%0d", d),  err[d], 1'b0);
         chk_b($sformatf("rst_mis%0d", d),  mis[d], 1'b0);
      end
      chk_d("rst_pass0", {32'd0, out0}, 64'h0000_0000_CAFE_F00D);
      chk_d("rst_pass1", out1,          64'h0123_4567_89AB_CDEF);
      chk_d("rst_pass2", {32'd0, out2}, 64'h0000_0000_1357_9BDF);
      chk_i("rst_ec0", int'(ec0), 0);
      chk_i("rst_ec2", int'(ec2), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // ---------------- instance 0: 32-bit, in-place lanes ----------------
      bigend[0] = 1'b1;
      exp_push(0, K_VLD, 64'hAA00_0000, 0);
      xfer(0, 1'b0, 32'h0000_0003, 3'd0, 64'hAABB_CCDD, 0, 1'b0);
      exp_push(0, K_VLD, 64'hAABB_0000, 0);
      xfer(0, 1'b0, 32'h0000_0102, 3'd1, 64'hAABB_CCDD, 1, 1'b0);
      bigend[0] = 1'b0;
      exp_push(0, K_VLD, 64'hAA00_0000, 0);
      xfer(0, 1'b0, 32'h0000_0000, 3'd0, 64'hAABB_CCDD, 0, 1'b0);
      exp_push(0, K_VLD, 64'h0000_CCDD, 0);
      xfer(0, 1'b0, 32'h0000_0002, 3'd1, 64'hAABB_CCDD, 0, 1'b0);
      bigend[0] = 1'b1;

      // Three back-to-back reads with hready held high
      exp_push(0, K_VLD, 64'h1122_3344, 0);
      exp_push(0, K_VLD, 64'h0000_7700, 0);
      exp_push(0, K_VLD, 64'h0000_BBCC, 0);
      htrans[0] = T_NSEQ; haddr[0] = 32'h40; hsize[0] = 3'd2; hwrite[0] = 1'b0; hready[0] = 1'b1;
      step();
      htrans[0] = T_SEQ; haddr[0] = 32'h41; hsize[0] = 3'd0; hrdata[0] = 64'h1122_3344;
      @(negedge clk); chk_b("b2b_busy_a", bsy[0], 1'b1);
      step();
      htrans[0] = T_SEQ; haddr[0] = 32'h44; hsize[0] = 3'd1; hrdata[0] = 64'h5566_7788;
      @(negedge clk); chk_b("b2b_busy_b", bsy[0], 1'b1);
      step();
      htrans[0] = T_IDLE; hrdata[0] = 64'h99AA_BBCC;
      @(negedge clk); chk_b("b2b_busy_c", bsy[0], 1'b1);
      step();
      @(negedge clk); chk_b("b2b_busy_end", bsy[0], 1'b0);
      step();

      // Read with two wait states then ERROR, then a write with ERROR, then a clean write
      exp_push(0, K_ERR, 64'd0, 0);
      xfer(0, 1'b0, 32'h0000_0008, 3'd2, 64'd0, 2, 1'b1);
      @(negedge clk); chk_i("ec0_after_rd_err", int'(ec0), 1);
      exp_push(0, K_ERR, 64'd0, 1);
      xfer(0, 1'b1, 32'h0000_000C, 3'd2, 64'd0, 0, 1'b1);
      @(negedge clk); chk_i("ec0_after_wr_err", int'(ec0), 2);
      xfer(0, 1'b1, 32'h0000_0010, 3'd2, 64'd0, 0, 1'b0);

      // ---------------- instance 1: 64-bit, right-justified ----------------
      bigend[1] = 1'b0;
      exp_push(1, K_VLD, 64'h0000_0000_0000_3344, 0);
      xfer(1, 1'b0, 32'h0000_0002, 3'd1, 64'h1122_3344_5566_7788, 0, 1'b0);
      exp_push(1, K_VLD, 64'h0000_0000_1122_3344, 0);
      xfer(1, 1'b0, 32'h0000_0000, 3'd2, 64'h1122_3344_5566_7788, 0, 1'b0);
      bigend[1] = 1'b1;
      exp_push(1, K_VLD, 64'h0000_0000_1122_3344, 0);
      xfer(1, 1'b0, 32'h0000_0004, 3'd2, 64'h1122_3344_5566_7788, 0, 1'b0);
      exp_push(1, K_VLD, 64'h1122_3344_5566_7788, 0);
      xfer(1, 1'b0, 32'h0000_0000, 3'd3, 64'h1122_3344_5566_7788, 0, 1'b0);
      exp_push(1, K_VLD, 64'h0000_0000_0000_0011, 0);
      xfer(1, 1'b0, 32'h0000_0007, 3'd0, 64'h1122_3344_5566_7788, 0, 1'b0);
      exp_push(1, K_MIS, 64'd0, 0);
      xfer(1, 1'b0, 32'h0000_0004, 3'd3, 64'h1122_3344_5566_7788, 0, 1'b0);

      // ---------------- instance 2: 32-bit, 2-bit counter ----------------
      for (int i = 0; i < 5; i++) begin
         exp_push(2, K_ERR, 64'd0, (i < 3) ? i : 3);
         xfer(2, 1'b0, 32'h0000_0000, 3'd2, 64'd0, 0, 1'b1);
      end
      @(negedge clk); chk_i("ec2_saturated", int'(ec2), 3);
      exp_push(2, K_MIS, 64'd0, 0);
      xfer(2, 1'b0, 32'h0000_0002, 3'd2, 64'hAABB_CCDD, 0, 1'b0);
      exp_push(2, K_MIS, 64'd0, 0);
      xfer(2, 1'b0, 32'h0000_0000, 3'd3, 64'hAABB_CCDD, 0, 1'b0);
      exp_push(2, K_VLD, 64'h0000_00BB, 0);
      xfer(2, 1'b0, 32'h0000_0002, 3'd0, 64'hAABB_CCDD, 0, 1'b0);
      bigend[2] = 1'b0;
      exp_push(2, K_VLD, 64'h0000_00AA, 0);
      xfer(2, 1'b0, 32'h0000_0000, 3'd0, 64'hAABB_CCDD, 0, 1'b0);
      bigend[2] = 1'b1;

      // ---------------- reset in the middle of a read data phase ----------------
      htrans[0] = T_NSEQ; haddr[0] = 32'h1; hsize[0] = 3'd0; hwrite[0] = 1'b0; hready[0] = 1'b1;
      step();
      htrans[0] = T_IDLE; hready[0] = 1'b0; hrdata[0] = 64'h1234_5678;
      @(negedge clk); chk_b("midrst_busy_before", bsy[0], 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk_b("midrst_busy", bsy[0], 1'b0);
      chk_b("midrst_vld", vld[0], 1'b0);
      chk_d("midrst_pass", {32'd0, out0}, 64'h1234_5678);
      hready[0] = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      step(); step(); step();
      hrdata[0] = 64'h9ABC_DEF0;
      @(negedge clk);
      chk_d("post_rst_pass", {32'd0, out0}, 64'h9ABC_DEF0);
      chk_i("post_rst_ec0", int'(ec0), 0);
      step();

      // Every expected completion was observed
      chk_i("drain_q0", q0.size(), 0);
      chk_i("drain_q1", q1.size(), 0);
      chk_i("drain_q2", q2.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
